// File: rtl/yolcu_besleyici.sv
// Passenger record FIFO feeding a fixed-latency downstream check; results return GECIKME cycles after issue.
// Optional macro YOLCU_SAYAC_EN adds saturating takeoff/refusal counters.
module yolcu_besleyici #(
  parameter int BIT      = 6,
  parameter int DERINLIK = 8,
  parameter int GECIKME  = 4
) (
  input  logic           saat,
  input  logic           reset,
  input  logic           yaz,
  input  logic [BIT-1:0] w_kimlik_no,
  input  logic           w_uyruk,
  input  logic [5:0]     w_agirlik,
  input  logic [8:0]     w_bakiye,
  output logic           dolu,
  output logic           bos,
  output logic           tasma,
  input  logic           gonder_en,
  output logic           mesgul,
  output logic [BIT-1:0] kimlik_no,
  output logic           uyruk,
  output logic [5:0]     agirlik,
  output logic [8:0]     bakiye,
  output logic           cikis_gecerli,
  input  logic           kalkis,
  input  logic [8:0]     k_bakiye,
  output logic           sonuc_gecerli,
  output logic [BIT-1:0] sonuc_kimlik,
  output logic           sonuc_kalkis,
  output logic [8:0]     sonuc_bakiye,
  output logic [7:0]     ucan_sayac,
  output logic [7:0]     red_sayac
);
  localparam int AW = $clog2(DERINLIK);

  typedef struct packed {
    logic [BIT-1:0] kimlik;
    logic           uyruk;
    logic [5:0]     agirlik;
    logic [8:0]     bakiye;
  } kayit_t;

  typedef struct packed {
    logic           gecerli;
    logic [BIT-1:0] kimlik;
  } ucus_t;

  typedef enum logic [1:0] {BOSTA = 2'd0, GONDER = 2'd1, BOSALT = 2'd2} durum_t;

  kayit_t         mem_q [DERINLIK];
  logic [AW:0]    wr_q, wr_d, rd_q, rd_d, sayi, sayi_d;
  durum_t         durum_q, durum_d;
  logic           tasma_q, tasma_d;
  kayit_t         cikis_q, cikis_d;
  logic           cg_q, cg_d;
  ucus_t          hat_q [GECIKME];
  ucus_t          hat_d [GECIKME];
  logic           sg_q, sg_d, skal_q, skal_d;
  logic [BIT-1:0] sk_q, sk_d;
  logic [8:0]     sbak_q, sbak_d;
  logic           push, pop, ucusta;
  kayit_t         yeni, bas;

  assign sayi = wr_q - rd_q;
  assign bos  = (sayi == '0);
  assign dolu = (sayi == (AW+1)'(DERINLIK));
  assign bas  = mem_q[rd_q[AW-1:0]];
  assign yeni = '{kimlik: w_kimlik_no, uyruk: w_uyruk, agirlik: w_agirlik, bakiye: w_bakiye};

  always_comb begin
    // Pop needs a non-empty queue, so a same-cycle push never bypasses storage.
    pop     = (durum_q == GONDER) && gonder_en && !bos;
    push    = yaz && (!dolu || pop);
    wr_d    = wr_q + (AW+1)'(push);
    rd_d    = rd_q + (AW+1)'(pop);
    sayi_d  = wr_d - rd_d;
    tasma_d = tasma_q | (yaz & ~push);
    cikis_d = pop ? bas : '0;
    cg_d    = pop;

    // hat[0] mirrors the issued record; hat[GECIKME-1] meets its downstream answer.
    hat_d[0] = '{gecerli: pop, kimlik: pop ? bas.kimlik : '0};
    for (int i = 1; i < GECIKME; i++) hat_d[i] = hat_q[i-1];
    ucusta = 1'b0;
    for (int i = 0; i < GECIKME; i++) ucusta = ucusta | hat_q[i].gecerli;

    sg_d   = hat_q[GECIKME-1].gecerli;
    sk_d   = sg_d ? hat_q[GECIKME-1].kimlik : '0;
    skal_d = sg_d & kalkis;
    sbak_d = sg_d ? k_bakiye : '0;

    durum_d = durum_q;
    case (durum_q)
      BOSTA:  if (gonder_en && !bos) durum_d = GONDER;
      GONDER: if (!gonder_en || sayi_d == '0) durum_d = BOSALT;
      BOSALT: begin
        if (gonder_en && !bos) durum_d = GONDER;
        else if (!ucusta)      durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge saat) begin
    if (push) mem_q[wr_q[AW-1:0]] <= yeni;
  end

  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      durum_q <= BOSTA;
      tasma_q <= 1'b0;
      cikis_q <= '0;
      cg_q    <= 1'b0;
      for (int i = 0; i < GECIKME; i++) hat_q[i] <= '0;
      sg_q    <= 1'b0;
      sk_q    <= '0;
      skal_q  <= 1'b0;
      sbak_q  <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      durum_q <= durum_d;
      tasma_q <= tasma_d;
      cikis_q <= cikis_d;
      cg_q    <= cg_d;
      for (int i = 0; i < GECIKME; i++) hat_q[i] <= hat_d[i];
      sg_q    <= sg_d;
      sk_q    <= sk_d;
      skal_q  <= skal_d;
      sbak_q  <= sbak_d;
    end
  end

  assign tasma         = tasma_q;
  assign mesgul        = (durum_q != BOSTA);
  assign kimlik_no     = cikis_q.kimlik;
  assign uyruk         = cikis_q.uyruk;
  assign agirlik       = cikis_q.agirlik;
  assign bakiye        = cikis_q.bakiye;
  assign cikis_gecerli = cg_q;
  assign sonuc_gecerli = sg_q;
  assign sonuc_kimlik  = sk_q;
  assign sonuc_kalkis  = skal_q;
  assign sonuc_bakiye  = sbak_q;

`ifdef YOLCU_SAYAC_EN
  logic [7:0] ucan_q, ucan_d, red_q, red_d;

  always_comb begin
    ucan_d = ucan_q;
    red_d  = red_q;
    if (hat_q[GECIKME-1].gecerli) begin
      if (kalkis) begin
        if (ucan_q != 8'hFF) ucan_d = ucan_q + 8'd1;
      end else if (red_q != 8'hFF) begin
        red_d = red_q + 8'd1;
      end
    end
  end

  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      ucan_q <= '0;
      red_q  <= '0;
    end else begin
      ucan_q <= ucan_d;
      red_q  <= red_d;
    end
  end

  assign ucan_sayac = ucan_q;
  assign red_sayac  = red_q;
`else
  assign ucan_sayac = '0;
  assign red_sayac  = '0;
`endif
endmodule
